// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//
// Receive-side buffer between the buart receiver and the CPU I/O read mux.
// Bytes are drained from buart with its valid/rd handshake and held in a
// DEPTH-entry FIFO, so the CPU may lag by up to DEPTH bytes without loss.
// The head byte, fill level and status bits are combinational from
// registers only; no uart_* input reaches an output without a flop.
//
// Parameters:
//   DEPTH_LOG2  log2 of FIFO depth (DEPTH = 2**DEPTH_LOG2)
//   DATA_W      byte width, matches buart rx_data
//
// Ports:
//   clk         system clock
//   resetq      synchronous reset, active-low
//   uart_valid  buart byte available (level, held until uart_rd)
//   uart_data   buart byte, stable while uart_valid=1
//   uart_rd     one-cycle acknowledge to buart
//   cpu_pop     one-cycle read strobe, pops the head byte
//   cpu_clr     one-cycle strobe, clears the sticky overrun flag
//   rd_data     head byte, 0 when empty
//   level       number of stored bytes, 0..DEPTH
//   status      [0]=not empty, [1]=full, [2]=overrun (sticky)
//
// Build option:
//   UART_RX_FIFO_OVERRUN_EN  when defined, a byte offered while the FIFO is
//   full (and not being popped) is acknowledged and dropped, setting the
//   overrun flag. When undefined the ingress FSM holds off (backpressure),
//   status[2] always reads 0 and cpu_clr has no visible effect.
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = 8
) (
    input  logic                  clk,
    input  logic                  resetq,
    input  logic                  uart_valid,
    input  logic [DATA_W-1:0]     uart_data,
    output logic                  uart_rd,
    input  logic                  cpu_pop,
    input  logic                  cpu_clr,
    output logic [DATA_W-1:0]     rd_data,
    output logic [DEPTH_LOG2:0]   level,
    output logic [2:0]            status
);

    // Ingress states
    //   state    | meaning
    //   ---------+-------------------------------------------------------
    //   ST_IDLE  | waiting for uart_valid; byte captured on the way out
    //   ST_ACK   | uart_rd high for this single cycle
    //   ST_WAIT  | waiting for buart to drop uart_valid (one byte per valid)
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam int                   DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]  LEVEL_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]  LEVEL_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

    state_t                  state_q, state_d;
    logic                    uart_rd_q, uart_rd_d;
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]     level_q, level_d;
    logic                    ovr_q, ovr_d;
    logic [DATA_W-1:0]       mem_q [DEPTH];

    logic                    full;
    logic                    empty;
    logic                    offer;
    logic                    accept;
    logic                    push;
    logic                    pop;
    logic                    drop;

    // level is the only full/empty authority; pointers just wrap.
    assign full  = (level_q == LEVEL_FULL);
    assign empty = (level_q == '0);

    always_comb begin
        pop    = cpu_pop & ~empty;
        // A pop in the same cycle frees the slot the push needs.
        accept = ~full | cpu_pop;
        offer  = (state_q == ST_IDLE) & uart_valid;
        push   = offer & accept;
`ifdef UART_RX_FIFO_OVERRUN_EN
        drop   = offer & ~accept;
`else
        drop   = 1'b0;
`endif
    end

    always_comb begin
        state_d   = state_q;
        uart_rd_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (push | drop) begin
                    state_d   = ST_ACK;
                    uart_rd_d = 1'b1;
                end
            end
            ST_ACK: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!uart_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LEVEL_ONE;
            2'b01:   level_d = level_q - LEVEL_ONE;
            default: level_d = level_q;
        endcase
    end

    // Set wins over clear. Without the overrun build drop is constant 0,
    // so the flag never leaves its reset value.
    always_comb begin
        ovr_d = ovr_q;
        if (drop) begin
            ovr_d = 1'b1;
        end else if (cpu_clr) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetq) begin
            state_q   <= ST_IDLE;
            uart_rd_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            uart_rd_q <= uart_rd_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            ovr_q     <= ovr_d;
        end
    end

    // Storage needs no reset; empty entries are masked on rd_data.
    always_ff @(posedge clk) begin
        if (resetq && push) begin
            mem_q[wr_ptr_q] <= uart_data;
        end
    end

    assign uart_rd = uart_rd_q;
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
    assign level   = level_q;
    assign status  = {ovr_q, full, ~empty};

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

    localparam int DL2   = 2;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       resetq = 1'b0;
    logic       uart_valid = 1'b0;
    logic [7:0] uart_data = 8'h00;
    logic       uart_rd;
    logic       cpu_pop = 1'b0;
    logic       cpu_clr = 1'b0;
    logic [7:0] rd_data;
    logic [DL2:0] level;
    logic [2:0] status;

    int checks = 0;
    int failures = 0;

    uart_rx_fifo #(.DEPTH_LOG2(DL2), .DATA_W(8)) dut (
        .clk        (clk),
        .resetq     (resetq),
        .uart_valid (uart_valid),
        .uart_data  (uart_data),
        .uart_rd    (uart_rd),
        .cpu_pop    (cpu_pop),
        .cpu_clr    (cpu_clr),
        .rd_data    (rd_data),
        .level      (level),
        .status     (status)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Queue of stored bytes, sticky overrun bit, and handshake phase:
    // 0 = free to take a byte, 1 = acknowledging, 2 = waiting for release.
    logic [7:0] m_q[$];
    int         m_phase = 0;
    bit         m_ovr = 0;
    bit         armed = 0;

    always @(posedge clk) begin : model
        bit cap;
        bit drp;
        bit was_full;
        if (!resetq) begin
            m_q.delete();
            m_phase = 0;
            m_ovr   = 0;
            armed   = 1;
        end else begin
            cap = 0;
            drp = 0;
            was_full = (m_q.size() == DEPTH);
            if (m_phase == 0 && uart_valid) begin
                if (!was_full || cpu_pop) cap = 1;
`ifdef UART_RX_FIFO_OVERRUN_EN
                else drp = 1;
`endif
            end
            if (m_phase == 0) begin
                if (cap || drp) m_phase = 1;
            end else if (m_phase == 1) begin
                m_phase = 2;
            end else if (!uart_valid) begin
                m_phase = 0;
            end
            if (cpu_pop && m_q.size() > 0) void'(m_q.pop_front());
            if (cap) m_q.push_back(uart_data);
            if (drp) m_ovr = 1;
            else if (cpu_clr) m_ovr = 0;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("m_uart_rd", {31'd0, uart_rd}, {31'd0, m_phase == 1});
            check("m_level", {29'd0, level}, m_q.size());
            check("m_rd_data", {24'd0, rd_data}, (m_q.size() > 0) ? {24'd0, m_q[0]} : 32'd0);
            check("m_status", {29'd0, status},
                  {29'd0, m_ovr, m_q.size() == DEPTH, m_q.size() != 0});
        end
    end

    // ---------------- directed helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    // Offer a byte while the ingress side is idle; buart drops valid as
    // soon as it sees uart_rd, then two cycles let the FSM return to idle.
    task automatic send(input logic [7:0] b);
        uart_valid = 1'b1;
        uart_data  = b;
        tick();
        check("send_rd_pulse", {31'd0, uart_rd}, 32'd1);
        uart_valid = 1'b0;
        tick();
        check("send_rd_single", {31'd0, uart_rd}, 32'd0);
        tick();
    endtask

    task automatic pop_expect(input logic [7:0] e);
        check("pop_head", {24'd0, rd_data}, {24'd0, e});
        cpu_pop = 1'b1;
        tick();
        cpu_pop = 1'b0;
    endtask

    task automatic expect_outs(input string name, input logic [2:0] lv,
                               input logic [2:0] st, input logic [7:0] rd);
        check({name, "_level"}, {29'd0, level}, {29'd0, lv});
        check({name, "_status"}, {29'd0, status}, {29'd0, st});
        check({name, "_rd_data"}, {24'd0, rd_data}, {24'd0, rd});
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        // Reset then idle
        resetq = 1'b0;
        tick();
        tick();
        check("rst_uart_rd", {31'd0, uart_rd}, 32'd0);
        expect_outs("rst", 3'd0, 3'b000, 8'h00);
        resetq = 1'b1;
        tick();
        cpu_pop = 1'b1;
        tick();
        cpu_pop = 1'b0;
        tick();
        expect_outs("empty_pop", 3'd0, 3'b000, 8'h00);

        // Single byte
        send(8'h41);
        expect_outs("single", 3'd1, 3'b001, 8'h41);
        pop_expect(8'h41);
        expect_outs("single_pop", 3'd0, 3'b000, 8'h00);

        // Fill and wrap
        for (int i = 1; i <= 4; i++) send(8'(i));
        expect_outs("fill", 3'd4, 3'b011, 8'h01);
        pop_expect(8'h01);
        pop_expect(8'h02);
        send(8'h05);
        send(8'h06);
        for (int i = 3; i <= 6; i++) pop_expect(8'(i));
        expect_outs("wrap_done", 3'd0, 3'b000, 8'h00);

        // Full plus simultaneous pop
        for (int i = 0; i < 4; i++) send(8'h10 + 8'(i));
        check("full_head", {24'd0, rd_data}, 32'h10);
        uart_valid = 1'b1;
        uart_data  = 8'h20;
        cpu_pop    = 1'b1;
        tick();
        cpu_pop    = 1'b0;
        check("fullpop_rd", {31'd0, uart_rd}, 32'd1);
        expect_outs("fullpop", 3'd4, 3'b011, 8'h11);
        uart_valid = 1'b0;
        tick();
        tick();
        pop_expect(8'h11);
        pop_expect(8'h12);
        pop_expect(8'h13);
        pop_expect(8'h20);

        // Full FIFO offered another byte
        for (int i = 0; i < 4; i++) send(8'h30 + 8'(i));
        uart_valid = 1'b1;
        uart_data  = 8'hEE;
`ifdef UART_RX_FIFO_OVERRUN_EN
        tick();
        check("ovr_rd", {31'd0, uart_rd}, 32'd1);
        expect_outs("ovr", 3'd4, 3'b111, 8'h30);
        uart_valid = 1'b0;
        tick();
        tick();
        check("ovr_head", {24'd0, rd_data}, 32'h30);
        cpu_clr = 1'b1;
        cpu_pop = 1'b1;
        tick();
        cpu_clr = 1'b0;
        cpu_pop = 1'b0;
        expect_outs("ovr_clr", 3'd3, 3'b001, 8'h31);
        pop_expect(8'h31);
        pop_expect(8'h32);
        pop_expect(8'h33);
        expect_outs("ovr_drained", 3'd0, 3'b000, 8'h00);
        // Set and clear together: set wins
        for (int i = 0; i < 4; i++) send(8'h40 + 8'(i));
        uart_valid = 1'b1;
        uart_data  = 8'hEE;
        cpu_clr    = 1'b1;
        tick();
        cpu_clr    = 1'b0;
        check("ovr_set_wins", {31'd0, status[2]}, 32'd1);
        uart_valid = 1'b0;
        tick();
        tick();
        cpu_clr = 1'b1;
        tick();
        cpu_clr = 1'b0;
        for (int i = 0; i < 4; i++) pop_expect(8'h40 + 8'(i));
`else
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_rd", {31'd0, uart_rd}, 32'd0);
            expect_outs("bp", 3'd4, 3'b011, 8'h30);
        end
        cpu_pop = 1'b1;
        cpu_clr = 1'b1;
        tick();
        cpu_pop = 1'b0;
        cpu_clr = 1'b0;
        check("bp_accept_rd", {31'd0, uart_rd}, 32'd1);
        expect_outs("bp_accept", 3'd4, 3'b011, 8'h31);
        uart_valid = 1'b0;
        tick();
        tick();
        pop_expect(8'h31);
        pop_expect(8'h32);
        pop_expect(8'h33);
        pop_expect(8'hEE);
`endif
        expect_outs("ovr_end", 3'd0, 3'b000, 8'h00);

        // Reset during the acknowledge cycle
        send(8'h55);
        uart_valid = 1'b1;
        uart_data  = 8'h66;
        tick();
        check("mid_ack_rd", {31'd0, uart_rd}, 32'd1);
        resetq = 1'b0;
        tick();
        check("mid_rst_rd", {31'd0, uart_rd}, 32'd0);
        expect_outs("mid_rst", 3'd0, 3'b000, 8'h00);
        resetq = 1'b1;
        tick();
        check("mid_recap_rd", {31'd0, uart_rd}, 32'd1);
        uart_valid = 1'b0;
        tick();
        tick();
        expect_outs("mid_recap", 3'd1, 3'b001, 8'h66);
        pop_expect(8'h66);
        tick();
        expect_outs("final", 3'd0, 3'b000, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer between the buart receiver and the CPU I/O bus decode.
- Drains bytes from buart using its valid/rd handshake and stores them in a small FIFO.
- Presents head byte, fill level and status bits to the I/O read mux, so the CPU can fall behind by up to DEPTH bytes without losing data.
- Pops on a one-cycle CPU read strobe.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth; DEPTH = 2**DEPTH_LOG2 entries.
- DATA_W, 8, byte width, matching buart rx_data.

Ports:
- clk  input  1  system clock (PLL output)
- resetq  input  1  synchronous reset, active-low
- uart_valid  input  1  buart rx byte available; level, held until uart_rd
- uart_data  input  DATA_W  buart rx byte, stable while uart_valid=1
- uart_rd  output  1  one-cycle acknowledge to buart; buart clears valid on it
- cpu_pop  input  1  one-cycle read strobe from I/O decode (io_read_enable & port bit)
- cpu_clr  input  1  one-cycle strobe; clears sticky overrun flag
- rd_data  output  DATA_W  head-of-FIFO byte; 0 when empty
- level  output  DEPTH_LOG2+1  number of stored bytes, 0..DEPTH
- status  output  3  [0]=not empty, [1]=full, [2]=overrun (sticky)

Behaviour:
- Reset: every flop updates only on posedge clk while resetq=0.
  - State goes to IDLE; pointers, level and overrun clear to 0.
  - uart_rd=0, rd_data=0, status=3'b000.
  - FIFO contents are don't-care.
- Reset mid-handshake: stored bytes are discarded. A byte still held by buart (uart_valid=1) is captured normally after release.
- Ingress FSM, three states:
  - IDLE: if uart_valid=1 and accept=1, write uart_data at wr_ptr and go to ACK. Otherwise stay.
    - accept = (level<DEPTH) | cpu_pop.
  - ACK: uart_rd=1 for exactly this one cycle. Go to WAIT.
  - WAIT: uart_rd=0. Stay until uart_valid=0, then go to IDLE. This guarantees one byte per buart valid assertion.
- uart_rd is registered and high only in ACK. The minimum per-byte cycle is IDLE→ACK→WAIT→IDLE, so at most one push every 3 cycles.
- Latency: uart_valid seen high in IDLE at edge N. level increments and the byte is visible in rd_data (if FIFO was empty) after edge N. uart_rd is high in cycle N+1.
- Pop:
  - cpu_pop with level>0 advances rd_ptr and decrements level at the next edge.
  - rd_data then shows the new head, or 0 if empty.
  - cpu_pop with level=0 is ignored: no pointer change, no error flag.
- Simultaneous push and pop (level>0): both take effect and level is unchanged. When full, the pop frees the slot used by the push.
- Simultaneous push and pop with level=0: push happens, pop is ignored, level becomes 1.
- Pointers are DEPTH_LOG2 bits and wrap modulo DEPTH. level is the authoritative full/empty indicator (no pointer-compare ambiguity).
- Full without simultaneous pop: behaviour depends on FIFO_OVERRUN_EN (see Optional Feature).
- rd_data and status are combinational from registers only. There is no path from uart_* inputs to outputs.
- Overrun flag: set on a dropped byte. Cleared by cpu_clr. If set and clear happen in the same cycle, set wins.

Optional Feature:
- Macro: UART_RX_FIFO_OVERRUN_EN.
- Defined:
  - When uart_valid=1 in IDLE and the FIFO is full with no pop, the byte is dropped.
  - The FSM still goes to ACK, so buart can keep receiving, and status[2] is set.
- Not defined:
  - The FSM stays in IDLE, applying backpressure and leaving the byte in buart (buart may itself overwrite it).
  - status[2] is tied to 0, and cpu_clr is ignored.

Test Plan:
- Reset then idle: resetq=0 for 2 cycles, then release. Required: uart_rd=0, level=0, status=000, rd_data=0. A later cpu_pop leaves all of these unchanged.
- Single byte: hold uart_valid=1 with uart_data=8'h41, and drop valid the cycle after uart_rd.
  - uart_rd is high for exactly 1 cycle, one cycle after capture.
  - level=1, rd_data=8'h41, status=001.
  - cpu_pop gives level=0 and rd_data=0.
- Fill and wrap with DEPTH_LOG2=2: push 8'h01..8'h04, giving level=4 and status=011. Pop 2, push 8'h05, 8'h06, then pop all. The popped sequence must be 01,02,03,04,05,06 in order.
- Full plus simultaneous pop: with FIFO full of 10..13, assert uart_valid(8'h20) and cpu_pop in the same cycle.
  - Push is accepted and level stays 4.
  - Draining gives 11,12,13,20.
- Overrun with UART_RX_FIFO_OVERRUN_EN: full FIFO, uart_valid with 8'hEE.
  - uart_rd pulses, status=111, and 8'hEE never appears.
  - Then cpu_clr and cpu_pop gives status=001 and level=3.
  - Without the macro: uart_rd stays 0 until a pop, after which 8'hEE is accepted.
- Reset mid-handshake: assert resetq=0 during the ACK cycle. uart_rd=0 the next cycle and level=0. With uart_valid still high after release, the byte is captured once.
